// File: rtl/cdb_pkg.sv
// Common data bus constants and the tag/value record shared by the broadcaster,
// the reservation stations and the ROB.
package cdb_pkg;

  localparam int ROB_TAG_W = 6;
  localparam int DATA_W    = 32;
  localparam int NUM_TAGS  = 16;

  localparam logic [ROB_TAG_W-1:0] invalidNum = 6'b010000;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    data;
  } cdb_entry_t;

  // Tags 0..15 name real ROB entries; anything else is dropped at the input.
  function automatic logic tag_is_valid(input logic [ROB_TAG_W-1:0] tag);
    return tag < ROB_TAG_W'(NUM_TAGS);
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: DEPTH-entry circular buffer with a combinational head
// view so the arbiter can read the oldest entry in the same cycle it pops it.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  cdb_entry_t                   push_entry,
  output cdb_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Collects completed results from the functional units and drives them onto the
// two CDB lanes as one-cycle strobes, round-robin across sources.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NSRC-1:0]             srcValid,
  input  logic [ROB_TAG_W*NSRC-1:0]   srcRobNum,
  input  logic [DATA_W*NSRC-1:0]      srcData,
  output logic [NSRC-1:0]             srcReady,
  output logic                        CDBiscast,
  output logic [ROB_TAG_W-1:0]        CDBrobNum,
  output logic [DATA_W-1:0]           CDBdata,
  output logic                        CDBiscast2,
  output logic [ROB_TAG_W-1:0]        CDBrobNum2,
  output logic [DATA_W-1:0]           CDBdata2
);

  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NLANE = 2;

  cdb_entry_t       head  [NSRC];
  logic [CNT_W-1:0] count [NSRC];
  logic [NSRC-1:0]  empty;
  logic [NSRC-1:0]  full;
  logic [NSRC-1:0]  push;
  logic [NSRC-1:0]  pop;

  logic [NLANE-1:0] cool;
  logic [NLANE-1:0] fire;
  logic [SRC_W-1:0] fire_src [NLANE];
  logic [SRC_W-1:0] rr_reg;
  logic [SRC_W-1:0] rr_next;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      cdb_entry_t in_entry;

      assign in_entry     = {srcRobNum[gi*ROB_TAG_W +: ROB_TAG_W], srcData[gi*DATA_W +: DATA_W]};
      // Out-of-range tags complete the handshake but are never queued.
      assign push[gi]     = srcValid[gi] && !full[gi] && !flush && tag_is_valid(in_entry.tag);
      assign srcReady[gi] = (count[gi] < CNT_W'(DEPTH));

      cdb_src_fifo #(
        .DEPTH(DEPTH)
      ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push[gi]),
        .pop       (pop[gi]),
        .push_entry(in_entry),
        .head      (head[gi]),
        .count     (count[gi]),
        .empty     (empty[gi]),
        .full      (full[gi])
      );
    end
  endgenerate

  // Scan from rr_reg; each non-empty source claims the lowest free lane, so a
  // source can never be granted twice in one cycle.
  always_comb begin
    logic [NLANE-1:0] free;
    logic [SRC_W-1:0] idx;
    free    = ~cool;
    idx     = '0;
    fire    = '0;
    pop     = '0;
    rr_next = rr_reg;
    for (int l = 0; l < NLANE; l++) fire_src[l] = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = SRC_W'((int'(rr_reg) + k) % NSRC);
      if (!empty[idx]) begin
        if (free[0]) begin
          free[0]     = 1'b0;
          fire[0]     = 1'b1;
          fire_src[0] = idx;
          pop[idx]    = 1'b1;
          rr_next     = SRC_W'((int'(idx) + 1) % NSRC);
        end else if (free[1]) begin
          free[1]     = 1'b0;
          fire[1]     = 1'b1;
          fire_src[1] = idx;
          pop[idx]    = 1'b1;
          rr_next     = SRC_W'((int'(idx) + 1) % NSRC);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rr_reg <= '0;
    else if (flush) rr_reg <= '0;
    else            rr_reg <= rr_next;
  end

  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      logic                 cast_reg;
      logic [ROB_TAG_W-1:0] tag_reg;
      logic [DATA_W-1:0]    data_reg;
      logic                 cool_reg;

      assign cool[gi] = cool_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cast_reg <= 1'b0;
          tag_reg  <= invalidNum;
          data_reg <= '0;
        end else if (flush || !fire[gi]) begin
          cast_reg <= 1'b0;
          tag_reg  <= invalidNum;
          data_reg <= '0;
        end else begin
          cast_reg <= 1'b1;
          tag_reg  <= head[fire_src[gi]].tag;
          data_reg <= head[fire_src[gi]].data;
        end
      end

      // Cooldown guarantees listeners a fresh rising edge; flush leaves it alone.
      always_ff @(posedge clock or posedge reset) begin
        if (reset)       cool_reg <= 1'b0;
        else if (!flush) cool_reg <= fire[gi];
      end
    end
  endgenerate

  assign CDBiscast  = g_lane[0].cast_reg;
  assign CDBrobNum  = g_lane[0].tag_reg;
  assign CDBdata    = g_lane[0].data_reg;
  assign CDBiscast2 = g_lane[1].cast_reg;
  assign CDBrobNum2 = g_lane[1].tag_reg;
  assign CDBdata2   = g_lane[1].data_reg;

endmodule
